// File: rtl/ahb_lite_arbiter2.sv
// Purpose: two-master AHB-Lite round-robin arbiter with bounded hold, plus address/data bus mux.
// Latency: muxes are combinational (no added latency); grant moves one HREADY=1 edge after the decision.
// Backpressure: HREADY=0 freezes grant, address owner, data owner and hold count; outputs stay stable.
module ahb_lite_arbiter2 #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int HOLD_MAX = 4
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          HBUSREQ_M0,
   input  logic [AW-1:0] HADDR_M0,
   input  logic [1:0]    HTRANS_M0,
   input  logic          HWRITE_M0,
   input  logic [2:0]    HSIZE_M0,
   input  logic [DW-1:0] HWDATA_M0,
   output logic          HGRANT_M0,
   input  logic          HBUSREQ_M1,
   input  logic [AW-1:0] HADDR_M1,
   input  logic [1:0]    HTRANS_M1,
   input  logic          HWRITE_M1,
   input  logic [2:0]    HSIZE_M1,
   input  logic [DW-1:0] HWDATA_M1,
   output logic          HGRANT_M1,
   input  logic          HREADY,
   output logic [AW-1:0] HADDR,
   output logic [1:0]    HTRANS,
   output logic          HWRITE,
   output logic [2:0]    HSIZE,
   output logic [DW-1:0] HWDATA,
   output logic          HMASTER
);

   localparam logic [1:0] HT_IDLE  = 2'b00;
   localparam int         CW       = ($clog2(HOLD_MAX) > 3) ? $clog2(HOLD_MAX) : 3;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

   logic          grant_q, grant_d;   // next address-phase owner
   logic          aown_q;             // current address-phase owner
   logic          down_q;             // current data-phase owner
   logic [CW-1:0] cnt_q, cnt_d;       // address phases since the grant last moved
   logic          park_q, park_d;     // grant is parked (nobody was requesting)
   logic          req_own, req_oth;
   logic          switch_grant;
   logic [1:0]    trans_mux;
   logic          xfer_act;

   // Raw transfer type of the address-phase owner; NONSEQ/SEQ both have bit 1 set.
   assign trans_mux = aown_q ? HTRANS_M1 : HTRANS_M0;
   assign xfer_act  = trans_mux[1];

   // Round-robin arbitration with bounded hold; only acts on HREADY=1 edges.
   // A parked grant belongs to the last-served master, so simultaneous fresh
   // requests go to the other one (out of reset that favours M1).
   always_comb begin
      req_own      = grant_q ? HBUSREQ_M1 : HBUSREQ_M0;
      req_oth      = grant_q ? HBUSREQ_M0 : HBUSREQ_M1;
      switch_grant = 1'b0;
      if (HREADY) begin
         if (!req_own && req_oth) begin
            switch_grant = 1'b1;
         end else if (req_own && req_oth &&
                      (park_q || ((cnt_q == CNT_LAST) && xfer_act))) begin
            switch_grant = 1'b1;
         end
      end
      grant_d = grant_q ^ switch_grant;
   end

   // Hold count: the outgoing owner still issues one address phase under the
   // old grant, and that phase is counted toward the new turn, so each owner
   // gets exactly HOLD_MAX transfers per turn under contention. Saturates at
   // HOLD_MAX-1 so a long solo run can still be preempted immediately.
   always_comb begin
      cnt_d  = cnt_q;
      park_d = park_q;
      if (HREADY) begin
         park_d = !(HBUSREQ_M0 || HBUSREQ_M1);
         if (switch_grant) begin
            cnt_d = '0;
         end else if (xfer_act && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Ownership pipeline grant -> address phase -> data phase; frozen while HREADY=0.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         grant_q <= 1'b0;
         aown_q  <= 1'b0;
         down_q  <= 1'b0;
         cnt_q   <= '0;
         park_q  <= 1'b1;
      end else if (HREADY) begin
         grant_q <= grant_d;
         aown_q  <= grant_q;
         down_q  <= aown_q;
         cnt_q   <= cnt_d;
         park_q  <= park_d;
      end
   end

   // Bus mux: address/control by address owner, write data by data owner.
   // Reset suppresses any transfer and write data so an in-flight access is dropped.
   always_comb begin
      HADDR  = aown_q ? HADDR_M1  : HADDR_M0;
      HWRITE = aown_q ? HWRITE_M1 : HWRITE_M0;
      HSIZE  = aown_q ? HSIZE_M1  : HSIZE_M0;
      HTRANS = HRESET ? HT_IDLE : trans_mux;
      HWDATA = HRESET ? '0 : (down_q ? HWDATA_M1 : HWDATA_M0);
   end

   assign HGRANT_M0 = !grant_q;
   assign HGRANT_M1 = grant_q;
   assign HMASTER   = aown_q;

endmodule
